// File: rtl/xor_nibble_packer_if.sv
// Bundle between the nibble producer / result-capture side and xor_nibble_packer.
// Optional XOR_PACK_PARITY_EN adds the out_parity signal.
interface xor_nibble_packer_if #(
    parameter int WORD_NIBS = 4,
    parameter int DEPTH     = 4
);
    localparam int W   = 4 * WORD_NIBS;
    localparam int FLW = $clog2(DEPTH + 1);
    localparam int PCW = $clog2(WORD_NIBS + 1);

    logic [3:0]     y;
    logic           y_valid;
    logic           flush;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic [FLW-1:0] fill_level;
    logic [PCW-1:0] partial_cnt;
    logic [7:0]     drop_cnt;
    logic           overflow;
`ifdef XOR_PACK_PARITY_EN
    logic           out_parity;
`endif

    // Producer / capture side drives the stream inputs and ready.
    modport master (
        output y, y_valid, flush, out_ready,
        input  out_data, out_valid, fill_level, partial_cnt, drop_cnt, overflow
`ifdef XOR_PACK_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  y, y_valid, flush, out_ready,
        output out_data, out_valid, fill_level, partial_cnt, drop_cnt, overflow
`ifdef XOR_PACK_PARITY_EN
        , output out_parity
`endif
    );
endinterface

// File: rtl/xor_nibble_packer.sv
// Packs the 4-bit xor_design result stream LSB-first into words, buffers them in a FIFO.
// Optional XOR_PACK_PARITY_EN stores per-word even parity and drives out_parity.
module xor_nibble_packer #(
    parameter int WORD_NIBS = 4,
    parameter int DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    xor_nibble_packer_if.slave bus
);
    localparam int W   = 4 * WORD_NIBS;
    localparam int FLW = $clog2(DEPTH + 1);
    localparam int PCW = $clog2(WORD_NIBS + 1);
    localparam int AW  = $clog2(DEPTH);

    function automatic logic parity_f(input logic [W-1:0] w);
        return ^w;
    endfunction

    logic [W-1:0]   pack_q, pack_d;
    logic [PCW-1:0] partial_q, partial_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FLW-1:0] count_q, count_d;
    logic [7:0]     drop_q, drop_d;
    logic           overflow_q, overflow_d;
    logic [W-1:0]   mem_q [DEPTH];
`ifdef XOR_PACK_PARITY_EN
    logic           par_q [DEPTH];
`endif

    logic [W-1:0]   word_s;
    logic [PCW-1:0] cnt_after_s;
    logic           push_s, pop_s, full_s, wr_en_s, drop_s;

    // Nibble insertion and push decision; flush and word completion share one push.
    always_comb begin
        word_s = pack_q;
        for (int i = 0; i < WORD_NIBS; i++) begin
            word_s[i*4 +: 4] = (bus.y_valid && (partial_q == PCW'(i))) ? bus.y : pack_q[i*4 +: 4];
        end
        cnt_after_s = partial_q + (bus.y_valid ? PCW'(1) : PCW'(0));
        push_s      = (cnt_after_s == PCW'(WORD_NIBS)) ||
                      (bus.flush && (cnt_after_s != {PCW{1'b0}}));
        pack_d      = push_s ? {W{1'b0}} : word_s;
        partial_d   = push_s ? {PCW{1'b0}} : cnt_after_s;
    end

    // FIFO bookkeeping; a full FIFO still accepts a push when the head leaves the same edge.
    always_comb begin
        pop_s      = (count_q != {FLW{1'b0}}) && bus.out_ready;
        full_s     = (count_q == FLW'(DEPTH));
        wr_en_s    = push_s && (!full_s || pop_s);
        drop_s     = push_s && full_s && !pop_s;
        wr_ptr_d   = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + FLW'(1);
            2'b01:   count_d = count_q - FLW'(1);
            default: count_d = count_q;
        endcase
        drop_d     = (drop_s && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
        overflow_d = overflow_q | drop_s;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pack_q     <= {W{1'b0}};
            partial_q  <= {PCW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {FLW{1'b0}};
            drop_q     <= 8'd0;
            overflow_q <= 1'b0;
        end else begin
            pack_q     <= pack_d;
            partial_q  <= partial_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads 0 afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
`ifdef XOR_PACK_PARITY_EN
                par_q[i] <= 1'b0;
`endif
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q] <= word_s;
`ifdef XOR_PACK_PARITY_EN
            par_q[wr_ptr_q] <= parity_f(word_s);
`endif
        end
    end

    assign bus.out_data    = mem_q[rd_ptr_q];
    assign bus.out_valid   = (count_q != {FLW{1'b0}});
    assign bus.fill_level  = count_q;
    assign bus.partial_cnt = partial_q;
    assign bus.drop_cnt    = drop_q;
    assign bus.overflow    = overflow_q;
`ifdef XOR_PACK_PARITY_EN
    assign bus.out_parity  = par_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_xor_nibble_packer.sv
// Directed bench for xor_nibble_packer (WORD_NIBS=4, DEPTH=4) with hand-computed expectations.
module tb_xor_nibble_packer;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    xor_nibble_packer_if #(.WORD_NIBS(4), .DEPTH(4)) bus ();

    xor_nibble_packer #(.WORD_NIBS(4), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nib(input logic [3:0] v);
        bus.y       = v;
        bus.y_valid = 1'b1;
        step();
        bus.y_valid = 1'b0;
    endtask

    task automatic word(input logic [15:0] w);
        for (int i = 0; i < 4; i++) nib(w[i*4 +: 4]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".data"}, 32'(bus.out_data), 32'd0);
        check({tag, ".fill"}, 32'(bus.fill_level), 32'd0);
        check({tag, ".part"}, 32'(bus.partial_cnt), 32'd0);
        check({tag, ".drop"}, 32'(bus.drop_cnt), 32'd0);
        check({tag, ".ovf"}, 32'(bus.overflow), 32'd0);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b0;
        bus.y         = 4'h0;
        bus.y_valid   = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        check_zero("rst");
        #4 reset = 1'b1;

        // Basic packing and pop.
        bus.out_ready = 1'b1;
        nib(4'h1);
        nib(4'h2);
        check("t1.part2", 32'(bus.partial_cnt), 32'd2);
        nib(4'h3);
        nib(4'h4);
        check("t1.valid", 32'(bus.out_valid), 32'd1);
        check("t1.data", 32'(bus.out_data), 32'h4321);
        check("t1.fill1", 32'(bus.fill_level), 32'd1);
        check("t1.part0", 32'(bus.partial_cnt), 32'd0);
        step();
        check("t1.fill0", 32'(bus.fill_level), 32'd0);
        check("t1.empty", 32'(bus.out_valid), 32'd0);

        // Overflow.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) nib(4'hA);
        check("t2.full", 32'(bus.fill_level), 32'd4);
        check("t2.nodrop", 32'(bus.drop_cnt), 32'd0);
        for (int i = 0; i < 4; i++) nib(4'hA);
        check("t2.drop", 32'(bus.drop_cnt), 32'd1);
        check("t2.ovf", 32'(bus.overflow), 32'd1);
        check("t2.fill", 32'(bus.fill_level), 32'd4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2.dvalid", 32'(bus.out_valid), 32'd1);
            check("t2.ddata", 32'(bus.out_data), 32'hAAAA);
            step();
        end
        check("t2.drained", 32'(bus.fill_level), 32'd0);
        check("t2.ovfsticky", 32'(bus.overflow), 32'd1);

        // Flush, flush with simultaneous nibble, empty flush, stall stability.
        bus.out_ready = 1'b0;
        nib(4'h5);
        nib(4'h6);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("t3.data", 32'(bus.out_data), 32'h0065);
        check("t3.part", 32'(bus.partial_cnt), 32'd0);
        check("t3.fill1", 32'(bus.fill_level), 32'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("t3.noop", 32'(bus.fill_level), 32'd1);
        check("t3.stable", 32'(bus.out_data), 32'h0065);
        nib(4'h7);
        bus.flush = 1'b1;
        nib(4'h8);
        bus.flush = 1'b0;
        check("t3.fill2", 32'(bus.fill_level), 32'd2);
        check("t3.part0", 32'(bus.partial_cnt), 32'd0);
        bus.out_ready = 1'b1;
        step();
        check("t3.flushy", 32'(bus.out_data), 32'h0087);
        step();
        check("t3.empty", 32'(bus.fill_level), 32'd0);

        // Push into a full FIFO with simultaneous pop.
        bus.out_ready = 1'b0;
        word(16'h1111);
        word(16'h2222);
        word(16'h3333);
        word(16'h5555);
        nib(4'h4);
        nib(4'h3);
        nib(4'h2);
        check("t4.full", 32'(bus.fill_level), 32'd4);
        bus.out_ready = 1'b1;
        nib(4'h1);
        check("t4.fill", 32'(bus.fill_level), 32'd4);
        check("t4.nodrop", 32'(bus.drop_cnt), 32'd1);
        check("t4.h1", 32'(bus.out_data), 32'h2222);
        step();
        check("t4.h2", 32'(bus.out_data), 32'h3333);
        step();
        check("t4.h3", 32'(bus.out_data), 32'h5555);
        step();
        check("t4.h4", 32'(bus.out_data), 32'h1234);
        step();
        check("t4.empty", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset mid-word with content in the FIFO.
        bus.out_ready = 1'b0;
        word(16'h7777);
        word(16'h7777);
        word(16'h7777);
        nib(4'h9);
        nib(4'h9);
        check("t5.fill3", 32'(bus.fill_level), 32'd3);
        check("t5.part2", 32'(bus.partial_cnt), 32'd2);
        #1 reset = 1'b0;
        #1;
        check_zero("t5.rst");
        #1 reset = 1'b1;
        word(16'hFEDC);
        check("t5.valid", 32'(bus.out_valid), 32'd1);
        check("t5.data", 32'(bus.out_data), 32'hFEDC);
        check("t5.fill", 32'(bus.fill_level), 32'd1);

`ifdef XOR_PACK_PARITY_EN
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        word(16'h0001);
        word(16'h0003);
        check("t6.par1", 32'(bus.out_parity), 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("t6.par0", 32'(bus.out_parity), 32'd0);
        check("t6.data", 32'(bus.out_data), 32'h0003);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
